// File: rtl/seg_msg_decoder.sv
// Seven-segment loopback decoder: glitch filter, glyph decode, and framed-message checker.
// Optional macro SEGDEC_ERRCNT_EN splits uio_out into 4-bit match and error counters.
module seg_msg_decoder #(
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] HOLD_R  = 3'(HOLD);
    localparam logic [4:0] C_BLANK = 5'h00;
    localparam logic [4:0] C_DP    = 5'h01;
    localparam logic [3:0] LAST_POS = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_MSG, S_END} state_t;

    function automatic logic [4:0] f_decode(input logic [7:0] p);
        case (p)
            8'h00:   f_decode = 5'h00;
            8'h80:   f_decode = 5'h01;
            8'h5B:   f_decode = 5'h02;
            8'h4F:   f_decode = 5'h03;
            8'h15:   f_decode = 5'h04;
            8'h7E:   f_decode = 5'h05;
            8'h0E:   f_decode = 5'h06;
            8'h5F:   f_decode = 5'h07;
            8'h3E:   f_decode = 5'h08;
            default: f_decode = 5'h1F;
        endcase
    endfunction

    // Message body after the dp marker: S E n O L G U L G O n U L
    function automatic logic [4:0] f_expect(input logic [3:0] pos);
        case (pos)
            4'd0:    f_expect = 5'h02;
            4'd1:    f_expect = 5'h03;
            4'd2:    f_expect = 5'h04;
            4'd3:    f_expect = 5'h05;
            4'd4:    f_expect = 5'h06;
            4'd5:    f_expect = 5'h07;
            4'd6:    f_expect = 5'h08;
            4'd7:    f_expect = 5'h06;
            4'd8:    f_expect = 5'h07;
            4'd9:    f_expect = 5'h05;
            4'd10:   f_expect = 5'h04;
            4'd11:   f_expect = 5'h08;
            4'd12:   f_expect = 5'h06;
            default: f_expect = 5'h1F;
        endcase
    endfunction

    logic [7:0] r_s1;
    logic [7:0] r_cand;
    logic [7:0] r_last;
    logic [2:0] r_run;
    state_t     r_state, w_state_n;
    logic [3:0] r_pos, w_pos_n;
    logic [4:0] r_code;
    logic       r_valid, r_match, r_error;
    logic       w_accept, w_match, w_error;
    logic [4:0] w_code;
    logic       w_unused;

    // r_last suppresses re-accepting the same pattern, so a short glitch that
    // returns to the already-accepted symbol does not emit it twice.
    assign w_accept = (r_run == HOLD_R) && (r_cand != r_last);
    assign w_code   = f_decode(r_cand);
    assign w_unused = &{1'b0, ena, uio_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_cand <= '0;
            r_last <= '0;
            r_run  <= HOLD_R;
        end else begin
            r_s1 <= ui_in;
            if (r_s1 != r_cand) begin
                r_cand <= r_s1;
                r_run  <= 3'd1;
            end else if (r_run != HOLD_R) begin
                r_run <= r_run + 3'd1;
            end
            if (w_accept) r_last <= r_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pos   <= w_pos_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_match   = 1'b0;
        w_error   = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_code == C_DP) begin
                        w_state_n = S_MSG;
                        w_pos_n   = '0;
                    end
                end
                S_MSG: begin
                    if (w_code == f_expect(r_pos)) begin
                        if (r_pos == LAST_POS) w_state_n = S_END;
                        else                   w_pos_n   = r_pos + 4'd1;
                    end else begin
                        w_error   = 1'b1;
                        w_pos_n   = '0;
                        w_state_n = (w_code == C_DP) ? S_MSG : S_IDLE;
                    end
                end
                S_END: begin
                    w_pos_n = '0;
                    if (w_code == C_BLANK) begin
                        w_match   = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_error   = 1'b1;
                        w_state_n = (w_code == C_DP) ? S_MSG : S_IDLE;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_pos_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) r_code <= w_code;
            r_valid <= w_accept;
            r_match <= w_match;
            r_error <= w_error;
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    logic [3:0] r_mcnt;
    logic [3:0] r_ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcnt <= '0;
            r_ecnt <= '0;
        end else begin
            if (w_match) r_mcnt <= r_mcnt + 4'd1;
            if (w_error) r_ecnt <= r_ecnt + 4'd1;
        end
    end

    assign uio_out = {r_ecnt, r_mcnt};
`else
    logic [7:0] r_mcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_mcnt <= '0;
        else if (w_match) r_mcnt <= r_mcnt + 8'd1;
    end

    assign uio_out = r_mcnt;
`endif

    assign uo_out = {r_error, r_match, r_valid, r_code};
    assign uio_oe = '1;

endmodule

// File: tb/tb_seg_msg_decoder.sv
// Scoreboard bench for seg_msg_decoder: HOLD=1 instance for framing, HOLD=3 instance for the glitch filter.
module tb_seg_msg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui1, ui3;
    logic [7:0] uo1, uio1, oe1;
    logic [7:0] uo3, uio3, oe3;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seg_msg_decoder #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui1), .uio_in(8'h00),
        .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
    );

    seg_msg_decoder #(.HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui3), .uio_in(8'h00),
        .uo_out(uo3), .uio_out(uio3), .uio_oe(oe3)
    );

    // v = {error, match, code}; cyc = cycle count at which the pulse must be visible
    typedef struct {
        logic [6:0]  v;
        int unsigned cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t x1, x3;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] frm [0:14] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E,
                               8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E, 8'h00};
    logic [4:0] cod [0:14] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                               5'h06, 5'h07, 5'h05, 5'h04, 5'h08, 5'h06, 5'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (uo1[5]) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid1: got code %0h expected no output", uo1[4:0]);
                end else begin
                    x1 = q1.pop_front();
                    chk("sym1", {25'b0, uo1[7:6], uo1[4:0]}, {25'b0, x1.v});
                    chk("lat1", cyc, x1.cyc);
                end
            end else if (uo1[7:6] != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse1: got %0h expected 0", uo1[7:6]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (uo3[5]) begin
                if (q3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid3: got code %0h expected no output", uo3[4:0]);
                end else begin
                    x3 = q3.pop_front();
                    chk("sym3", {25'b0, uo3[7:6], uo3[4:0]}, {25'b0, x3.v});
                    chk("lat3", cyc, x3.cyc);
                end
            end else if (uo3[7:6] != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse3: got %0h expected 0", uo3[7:6]);
            end
        end
    end

    // HOLD=1: sampled at the next edge, output two edges later
    task automatic d1(input logic [7:0] p, input logic [4:0] c, input logic m, input logic e);
        @(negedge clk);
        ui1 = p;
        q1.push_back('{v: {e, m, c}, cyc: cyc + 3});
    endtask

    task automatic send_frame(input int bad, input int err_at);
        for (int i = 0; i < 15; i++) begin
            if (i == bad) d1(8'h7F, 5'h1F, 1'b0, 1'b1);
            else          d1(frm[i], cod[i], (i == 14) && (bad < 0), i == err_at);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && q3.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", q1.size() + q3.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ui1   = 8'h5B;
        ui3   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_uo", uo1, 8'h00);
        chk("rst_uio", uio1, 8'h00);
        chk("rst_oe", oe1, 8'hFF);
        chk("rst_uo3", uo3, 8'h00);
        ui1 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_uo", uo1, 8'h00);

        // Glitch filter on HOLD=3: 5B x4, 4F x1, 5B x4 -> one accept
        @(negedge clk);
        ui3 = 8'h5B;
        q3.push_back('{v: {2'b00, 5'h02}, cyc: cyc + 5});
        repeat (4) @(negedge clk);
        ui3 = 8'h4F;
        @(negedge clk);
        ui3 = 8'h5B;
        repeat (4) @(negedge clk);
        ui3 = 8'h00;
        q3.push_back('{v: {2'b00, 5'h00}, cyc: cyc + 5});
        drain();
        chk("oe3", oe3, 8'hFF);
        chk("uio3", uio3, 8'h00);

        // Three clean frames
        for (int f = 0; f < 3; f++) send_frame(-1, -1);
        drain();
        chk("cnt_3frames", uio1, 8'h03);

        // Corrupted frame, then clean frame
        send_frame(5, 5);
        drain();
`ifdef SEGDEC_ERRCNT_EN
        chk("cnt_bad", uio1, 8'h13);
`else
        chk("cnt_bad", uio1, 8'h03);
`endif
        send_frame(-1, -1);
        drain();
`ifdef SEGDEC_ERRCNT_EN
        chk("cnt_recover", uio1, 8'h14);
`else
        chk("cnt_recover", uio1, 8'h04);
`endif

        // Restart on dp: 80,5B then a full frame whose leading 80 breaks the first attempt
        d1(8'h80, 5'h01, 1'b0, 1'b0);
        d1(8'h5B, 5'h02, 1'b0, 1'b0);
        send_frame(-1, 0);
        drain();
`ifdef SEGDEC_ERRCNT_EN
        chk("cnt_restart", uio1, 8'h25);
`else
        chk("cnt_restart", uio1, 8'h05);
`endif

        // Reset after O is accepted discards the partial frame
        for (int i = 0; i < 5; i++) d1(frm[i], cod[i], 1'b0, 1'b0);
        drain();
        rst_n = 1'b0;
        ui1   = 8'h00;
        @(negedge clk);
        chk("midrst_uo", uo1, 8'h00);
        chk("midrst_uio", uio1, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(-1, -1);
        drain();
        chk("cnt_after_rst", uio1, 8'h01);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
